// File: rtl/avalon_mem_arbiter_if.sv
// Avalon request/response types and the bundle that carries them between a master and a slave.
// The package comes first so the interface and the arbiter can both import it.
package avalon_mem_arbiter_pkg;
   typedef struct packed {
      logic        read;
      logic        write;
      logic [31:0] address;
      logic [3:0]  byte_enable;
      logic [31:0] writedata;
   } avalon_req_t;

   typedef struct packed {
      logic [31:0] readdata;
      logic        waitrequest;
   } avalon_resp_t;
endpackage

interface avalon_mem_arbiter_if;
   import avalon_mem_arbiter_pkg::*;

   avalon_req_t  req;
   avalon_resp_t resp;

   modport master (output req, input resp);
   modport slave  (input req, output resp);
endinterface

// File: rtl/avalon_mem_arbiter.sv
// Two-port Avalon arbiter (I-cache on port 0, D-cache on port 1) with zero-cycle arbitration,
// grant lock while stalled, and broadcast read data. Define ARB_ROUND_ROBIN_EN for round-robin ties.
module avalon_mem_arbiter
   import avalon_mem_arbiter_pkg::*;
#(
   parameter bit PRIO_PORT = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst,
   avalon_mem_arbiter_if.slave   p0_avn,
   avalon_mem_arbiter_if.slave   p1_avn,
   avalon_mem_arbiter_if.master  mem_avn
);

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   state_t      r_state;
   state_t      w_state_next;
   logic        r_owner;
   logic        w_owner_next;

   logic        w_req0;
   logic        w_req1;
   logic        w_sel;
   logic        w_sel_req;
   logic        w_tie_sel;
   logic        w_wait0;
   logic        w_wait1;
   avalon_req_t w_fwd;

   assign w_req0 = p0_avn.req.read | p0_avn.req.write;
   assign w_req1 = p1_avn.req.read | p1_avn.req.write;

`ifdef ARB_ROUND_ROBIN_EN
   logic r_rr_last;
   logic w_accept;

   // Ties go to whichever port was not granted last, so contention alternates.
   assign w_tie_sel = ~r_rr_last;
   assign w_accept  = w_sel_req & ~mem_avn.resp.waitrequest;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rr_last <= ~PRIO_PORT;
      end else if (w_accept) begin
         r_rr_last <= w_sel;
      end
   end
`else
   assign w_tie_sel = PRIO_PORT;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_owner <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_owner <= w_owner_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_owner_next = r_owner;
      w_sel        = PRIO_PORT;
      w_sel_req    = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_req0 && w_req1) begin
               w_sel = w_tie_sel;
            end else if (w_req1) begin
               w_sel = 1'b1;
            end else if (w_req0) begin
               w_sel = 1'b0;
            end
            w_sel_req = w_sel ? w_req1 : w_req0;
            if (w_sel_req && mem_avn.resp.waitrequest) begin
               w_state_next = LOCKED;
               w_owner_next = w_sel;
            end
         end
         LOCKED: begin
            w_sel     = r_owner;
            w_sel_req = r_owner ? w_req1 : w_req0;
            // Release on completion, or if the owner dropped its request mid-stall.
            if (!w_sel_req || !mem_avn.resp.waitrequest) begin
               w_state_next = IDLE;
            end
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   always_comb begin
      w_fwd = w_sel ? p1_avn.req : p0_avn.req;
      w_wait0 = 1'b0;
      w_wait1 = 1'b0;
      if (rst) begin
         w_fwd.read  = 1'b0;
         w_fwd.write = 1'b0;
      end else begin
         w_wait0 = (w_sel == 1'b0) ? mem_avn.resp.waitrequest : w_req0;
         w_wait1 = (w_sel == 1'b1) ? mem_avn.resp.waitrequest : w_req1;
      end
   end

   assign mem_avn.req = w_fwd;

   // Read data is broadcast; each cache knows from its own accept when to sample it.
   assign p0_avn.resp = '{readdata: mem_avn.resp.readdata, waitrequest: w_wait0};
   assign p1_avn.resp = '{readdata: mem_avn.resp.readdata, waitrequest: w_wait1};

endmodule
